// File: rtl/logmap_axil_pkg.sv
// logmap_axil_pkg
//   Shared constants and types for the logmap AXI4-Lite control slave:
//   AXI response codes, the register count and index type, and the
//   write/read channel state encodings.
package logmap_axil_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam int NUM_REGS  = 4;
   localparam int REG_IDX_W = 2;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_COMMIT,
      WR_RESP
   } wr_state_t;

   typedef enum logic {
      RD_IDLE,
      RD_DATA
   } rd_state_t;

endpackage

// File: rtl/logmap_axil_regfile.sv
// logmap_axil_regfile
//   Byte-strobed array of 32-bit control registers with one write port,
//   one combinational read port and a one-cycle write pulse per register.
//   The pulse is raised on the same edge that commits the write, and it
//   fires even if no byte lane is enabled.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   wr_en     : commit a write this cycle
//   wr_idx    : register index being written
//   wr_data   : write data
//   wr_strb   : byte-lane enables
//   rd_idx    : register index being read
//   rd_data   : combinational read data
//   regs_flat : all registers, reg k at bits [32k+31:32k]
//   wr_pulse  : one-cycle pulse per register on write commit
module logmap_axil_regfile
   import logmap_axil_pkg::*;
#(
   parameter int C_NUM_REGS = NUM_REGS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  reg_idx_t                 wr_idx,
   input  logic [31:0]              wr_data,
   input  logic [3:0]               wr_strb,
   input  reg_idx_t                 rd_idx,
   output logic [31:0]              rd_data,
   output logic [C_NUM_REGS*32-1:0] regs_flat,
   output logic [C_NUM_REGS-1:0]    wr_pulse
);

   logic [31:0] regs [C_NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < C_NUM_REGS; k++) begin
            regs[k] <= '0;
         end
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
               if (wr_strb[b]) begin
                  regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
            wr_pulse[wr_idx] <= 1'b1;
         end
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int k = 0; k < C_NUM_REGS; k++) begin
         regs_flat[32*k +: 32] = regs[k];
      end
   end

   assign rd_data = regs[rd_idx];

endmodule

// File: rtl/logmap_axil_slave.sv
// logmap_axil_slave
//   AXI4-Lite slave for the logmap control interface. Single-beat writes
//   and reads target four 32-bit registers at word addresses 0..3; the
//   registers and per-register write pulses are exported to the core.
//   Address bits [1:0] are ignored (word-truncated). Only a 32-bit data
//   width is supported.
//
//   Build option: LOGMAP_AXIL_SLVERR_EN -- when defined, accesses beyond
//   the implemented registers answer SLVERR instead of OKAY.
//
// Ports
//   ACLK, ARESETN       : clock, synchronous active-low reset
//   S_AXI_AW*           : write address channel (AWPROT ignored)
//   S_AXI_W*            : write data channel
//   S_AXI_B*            : write response channel
//   S_AXI_AR*           : read address channel (ARPROT ignored)
//   S_AXI_R*            : read data channel
//   slv_reg_o           : flattened registers, reg k at [32k+31:32k]
//   reg_wr_pulse_o      : one-cycle pulse per register on write commit
//
// Write FSM
//   state     | meaning
//   WR_IDLE   | collecting AW and W, in any order
//   WR_COMMIT | both captured; register update and BVALID on this edge
//   WR_RESP   | BVALID held until BREADY
//
// Read FSM
//   state     | meaning
//   RD_IDLE   | ARREADY high, waiting for ARVALID
//   RD_DATA   | RVALID held with latched RDATA until RREADY
module logmap_axil_slave
   import logmap_axil_pkg::*;
#(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_ADDR_WIDTH = 6,
   parameter int C_NUM_REGS   = NUM_REGS
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic [C_ADDR_WIDTH-1:0]  S_AXI_AWADDR,
   input  logic [2:0]               S_AXI_AWPROT,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [C_DATA_WIDTH-1:0]  S_AXI_WDATA,
   input  logic [3:0]               S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   input  logic [C_ADDR_WIDTH-1:0]  S_AXI_ARADDR,
   input  logic [2:0]               S_AXI_ARPROT,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   output logic [C_DATA_WIDTH-1:0]  S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   output logic [C_NUM_REGS*32-1:0] slv_reg_o,
   output logic [C_NUM_REGS-1:0]    reg_wr_pulse_o
);

   localparam int IDX_W = C_ADDR_WIDTH - 2;
   localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(C_NUM_REGS);

   // write channel
   wr_state_t               wr_state, wr_state_d;
   logic                    aw_flag, aw_flag_d;
   logic                    w_flag, w_flag_d;
   logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
   logic [31:0]             w_data_q, w_data_d;
   logic [3:0]              w_strb_q, w_strb_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    bvalid_q, bvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic                    aw_hs, w_hs, aw_in_range, rf_wr_en;

   // read channel
   rd_state_t               rd_state, rd_state_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic [IDX_W-1:0]        ar_idx;
   logic                    ar_hs, ar_in_range;
   logic [31:0]             rf_rd_data;

   logic                    unused_ok;

   assign aw_hs       = S_AXI_AWVALID & awready_q;
   assign w_hs        = S_AXI_WVALID  & wready_q;
   assign aw_in_range = (aw_idx_q < NUM_REGS_IDX);
   assign rf_wr_en    = (wr_state == WR_COMMIT) && aw_in_range;

   assign ar_idx      = S_AXI_ARADDR[C_ADDR_WIDTH-1:2];
   assign ar_hs       = S_AXI_ARVALID & arready_q;
   assign ar_in_range = (ar_idx < NUM_REGS_IDX);

   assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   logmap_axil_regfile #(
      .C_NUM_REGS (C_NUM_REGS)
   ) u_regfile (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .wr_en     (rf_wr_en),
      .wr_idx    (aw_idx_q[REG_IDX_W-1:0]),
      .wr_data   (w_data_q),
      .wr_strb   (w_strb_q),
      .rd_idx    (ar_idx[REG_IDX_W-1:0]),
      .rd_data   (rf_rd_data),
      .regs_flat (slv_reg_o),
      .wr_pulse  (reg_wr_pulse_o)
   );

   // ---------------- write channel ----------------
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wr_state  <= WR_IDLE;
         aw_flag   <= 1'b0;
         w_flag    <= 1'b0;
         aw_idx_q  <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= AXI_RESP_OKAY;
      end else begin
         wr_state  <= wr_state_d;
         aw_flag   <= aw_flag_d;
         w_flag    <= w_flag_d;
         aw_idx_q  <= aw_idx_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   always_comb begin
      wr_state_d = wr_state;
      case (wr_state)
         WR_IDLE:   if ((aw_flag | aw_hs) && (w_flag | w_hs)) wr_state_d = WR_COMMIT;
         WR_COMMIT: wr_state_d = WR_RESP;
         WR_RESP:   if (S_AXI_BREADY) wr_state_d = WR_IDLE;
         default:   wr_state_d = WR_IDLE;
      endcase
   end

   always_comb begin
      aw_flag_d = aw_flag;
      w_flag_d  = w_flag;
      aw_idx_d  = aw_idx_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      case (wr_state)
         WR_IDLE: begin
            if (aw_hs) begin
               aw_flag_d = 1'b1;
               aw_idx_d  = S_AXI_AWADDR[C_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
               w_flag_d = 1'b1;
               w_data_d = S_AXI_WDATA[31:0];
               w_strb_d = S_AXI_WSTRB;
            end
         end
         WR_COMMIT: begin
            aw_flag_d = 1'b0;
            w_flag_d  = 1'b0;
            bvalid_d  = 1'b1;
`ifdef LOGMAP_AXIL_SLVERR_EN
            bresp_d   = aw_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
`else
            bresp_d   = AXI_RESP_OKAY;
`endif
         end
         WR_RESP: begin
            if (S_AXI_BREADY) bvalid_d = 1'b0;
         end
         default: begin
            aw_flag_d = 1'b0;
            w_flag_d  = 1'b0;
            bvalid_d  = 1'b0;
         end
      endcase
      // READYs are registered: they reflect where the FSM lands next
      awready_d = (wr_state_d == WR_IDLE) && !aw_flag_d;
      wready_d  = (wr_state_d == WR_IDLE) && !w_flag_d;
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;

   // ---------------- read channel ----------------
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         rd_state  <= RD_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= AXI_RESP_OKAY;
      end else begin
         rd_state  <= rd_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   always_comb begin
      rd_state_d = rd_state;
      case (rd_state)
         RD_IDLE: if (ar_hs) rd_state_d = RD_DATA;
         RD_DATA: if (S_AXI_RREADY) rd_state_d = RD_IDLE;
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Read data is sampled from the pre-commit register contents, so a
   // read racing a commit to the same register returns the old value.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      case (rd_state)
         RD_IDLE: begin
            if (ar_hs) begin
               rvalid_d = 1'b1;
               rdata_d  = ar_in_range ? rf_rd_data : '0;
`ifdef LOGMAP_AXIL_SLVERR_EN
               rresp_d  = ar_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
`else
               rresp_d  = AXI_RESP_OKAY;
`endif
            end
         end
         RD_DATA: begin
            if (S_AXI_RREADY) rvalid_d = 1'b0;
         end
         default: rvalid_d = 1'b0;
      endcase
      arready_d = (rd_state_d == RD_IDLE);
   end

   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = C_DATA_WIDTH'(rdata_q);
   assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_logmap_axil_slave.sv
module tb_logmap_axil_slave;

   localparam logic [1:0] OKAY = 2'b00;
`ifdef LOGMAP_AXIL_SLVERR_EN
   localparam logic [1:0] OOR_RESP = 2'b10;
`else
   localparam logic [1:0] OOR_RESP = 2'b00;
`endif

   logic         clk = 1'b0;
   logic         aresetn;
   logic [5:0]   awaddr;
   logic [2:0]   awprot;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [5:0]   araddr;
   logic [2:0]   arprot;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [127:0] slv_reg;
   logic [3:0]   pulse;

   int n_cmp = 0;
   int n_err = 0;
   int pulse_cnt [4] = '{0, 0, 0, 0};
   int snap [4];

   always #5 clk = ~clk;

   logmap_axil_slave dut (
      .ACLK           (clk),
      .ARESETN        (aresetn),
      .S_AXI_AWADDR   (awaddr),
      .S_AXI_AWPROT   (awprot),
      .S_AXI_AWVALID  (awvalid),
      .S_AXI_AWREADY  (awready),
      .S_AXI_WDATA    (wdata),
      .S_AXI_WSTRB    (wstrb),
      .S_AXI_WVALID   (wvalid),
      .S_AXI_WREADY   (wready),
      .S_AXI_BRESP    (bresp),
      .S_AXI_BVALID   (bvalid),
      .S_AXI_BREADY   (bready),
      .S_AXI_ARADDR   (araddr),
      .S_AXI_ARPROT   (arprot),
      .S_AXI_ARVALID  (arvalid),
      .S_AXI_ARREADY  (arready),
      .S_AXI_RDATA    (rdata),
      .S_AXI_RRESP    (rresp),
      .S_AXI_RVALID   (rvalid),
      .S_AXI_RREADY   (rready),
      .slv_reg_o      (slv_reg),
      .reg_wr_pulse_o (pulse)
   );

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (pulse[k] === 1'b1) pulse_cnt[k] = pulse_cnt[k] + 1;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_pulses(input string name, input int d0, input int d1, input int d2, input int d3);
      check({name, " pulse0"}, 128'(pulse_cnt[0] - snap[0]), 128'(d0));
      check({name, " pulse1"}, 128'(pulse_cnt[1] - snap[1]), 128'(d1));
      check({name, " pulse2"}, 128'(pulse_cnt[2] - snap[2]), 128'(d2));
      check({name, " pulse3"}, 128'(pulse_cnt[3] - snap[3]), 128'(d3));
   endtask

   task automatic take_snap();
      for (int k = 0; k < 4; k++) snap[k] = pulse_cnt[k];
   endtask

   // AW and W presented together; BREADY held low for 'hold' cycles once BVALID rises
   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input int hold, input string name);
      bit aw_done, w_done, aw_hit, w_hit;
      awaddr = addr; awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      bready = (hold == 0);
      aw_done = 0; w_done = 0;
      for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
         aw_hit = awvalid && awready;
         w_hit  = wvalid && wready;
         tick();
         if (aw_hit) begin aw_done = 1; awvalid = 1'b0; end
         if (w_hit)  begin w_done = 1;  wvalid = 1'b0; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check({name, " aw/w accepted"}, {aw_done, w_done}, 2'b11);
      for (int i = 0; i < 20 && bvalid !== 1'b1; i++) tick();
      check({name, " bvalid"}, bvalid, 1'b1);
      check({name, " bresp"}, bresp, exp_resp);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({name, " hold bvalid"}, bvalid, 1'b1);
         check({name, " hold bresp"}, bresp, exp_resp);
         check({name, " hold ready low"}, {awready, wready}, 2'b00);
      end
      bready = 1'b1;
      tick();
      check({name, " bvalid cleared"}, bvalid, 1'b0);
      check({name, " readys back"}, {awready, wready}, 2'b11);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input int hold, input string name);
      bit done, hit;
      araddr = addr; arvalid = 1'b1;
      rready = (hold == 0);
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         hit = arvalid && arready;
         tick();
         if (hit) begin done = 1; arvalid = 1'b0; end
      end
      arvalid = 1'b0;
      check({name, " ar accepted"}, done, 1'b1);
      for (int i = 0; i < 20 && rvalid !== 1'b1; i++) tick();
      check({name, " rvalid"}, rvalid, 1'b1);
      check({name, " rdata"}, rdata, exp_data);
      check({name, " rresp"}, rresp, exp_resp);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({name, " hold rvalid"}, rvalid, 1'b1);
         check({name, " hold rdata"}, rdata, exp_data);
         check({name, " hold arready low"}, arready, 1'b0);
      end
      rready = 1'b1;
      tick();
      check({name, " rvalid cleared"}, rvalid, 1'b0);
      check({name, " arready back"}, arready, 1'b1);
      rready = 1'b0;
   endtask

   typedef struct {
      bit          is_wr;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, 6'h00, 32'h1,        4'hF, 32'h0, OKAY};
      vecs[1]  = '{1'b1, 6'h04, 32'h2,        4'hF, 32'h0, OKAY};
      vecs[2]  = '{1'b1, 6'h08, 32'h3,        4'hF, 32'h0, OKAY};
      vecs[3]  = '{1'b1, 6'h0C, 32'h4,        4'hF, 32'h0, OKAY};
      vecs[4]  = '{1'b1, 6'h20, 32'hFFFFFFFF, 4'hF, 32'h0, OOR_RESP};
      vecs[5]  = '{1'b0, 6'h00, 32'h0,        4'h0, 32'h1, OKAY};
      vecs[6]  = '{1'b0, 6'h04, 32'h0,        4'h0, 32'h2, OKAY};
      vecs[7]  = '{1'b0, 6'h08, 32'h0,        4'h0, 32'h3, OKAY};
      vecs[8]  = '{1'b0, 6'h0C, 32'h0,        4'h0, 32'h4, OKAY};
      vecs[9]  = '{1'b0, 6'h3C, 32'h0,        4'h0, 32'h0, OOR_RESP};
      vecs[10] = '{1'b0, 6'h05, 32'h0,        4'h0, 32'h2, OKAY};
      vecs[11] = '{1'b0, 6'h0F, 32'h0,        4'h0, 32'h4, OKAY};

      aresetn = 1'b0;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

      // reset state
      repeat (3) tick();
      check("reset readys", {awready, wready, arready}, 3'b000);
      check("reset valids", {bvalid, rvalid}, 2'b00);
      check("reset resp/rdata", {bresp, rresp, rdata}, 36'h0);
      check("reset regs", slv_reg, 128'h0);
      check("reset pulses", pulse, 4'h0);
      aresetn = 1'b1;
      tick();
      check("readys after reset", {awready, wready, arready}, 3'b111);

      // table-driven basic writes and reads
      take_snap();
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].is_wr)
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, 0, $sformatf("vec%0d wr", i));
         else
            axi_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, 0, $sformatf("vec%0d rd", i));
      end
      check("table regs", slv_reg, 128'h00000004_00000003_00000002_00000001);
      check_pulses("table", 1, 1, 1, 1);

      // W three cycles ahead of AW
      take_snap();
      wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      check("wfirst wready", wready, 1'b1);
      tick();
      wvalid = 1'b0;
      check("wfirst wready dropped", wready, 1'b0);
      check("wfirst awready held", awready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("wfirst no commit", {bvalid, slv_reg[63:32]}, {1'b0, 32'h2});
         if (i < 2) tick();
      end
      awaddr = 6'h04; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("wfirst commit cycle", {bvalid, awready, wready}, 3'b000);
      tick();
      check("wfirst bvalid", {bvalid, bresp}, {1'b1, OKAY});
      check("wfirst reg1", slv_reg[63:32], 32'hDEADBEEF);
      check("wfirst pulse", pulse, 4'b0010);
      tick();
      check("wfirst done", {bvalid, awready, wready, pulse}, {3'b011, 4'b0000});
      bready = 1'b0;
      check_pulses("wfirst", 0, 1, 0, 0);

      // byte strobes, including an empty strobe
      axi_write(6'h08, 32'h11223344, 4'hF, OKAY, 0, "strb full");
      take_snap();
      axi_write(6'h08, 32'hAABBCCDD, 4'b0101, OKAY, 0, "strb 0101");
      check("strb reg2", slv_reg[95:64], 32'h11BB33DD);
      check_pulses("strb", 0, 0, 1, 0);
      take_snap();
      axi_write(6'h0C, 32'hFFFFFFFF, 4'b0000, OKAY, 0, "strb none");
      check("strb none reg3", slv_reg[127:96], 32'h4);
      check_pulses("strb none", 0, 0, 0, 1);

      // backpressure on both response channels
      axi_write(6'h0C, 32'h55, 4'hF, OKAY, 5, "bhold");
      axi_read(6'h0C, 32'h55, OKAY, 5, "rhold");

      // read racing a commit to the same register sees the old value
      awaddr = 6'h00; awvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 6'h00; arvalid = 1'b1; rready = 1'b1;
      check("race arready", arready, 1'b1);
      tick();
      arvalid = 1'b0;
      check("race rdata old", {rvalid, rdata}, {1'b1, 32'h1});
      check("race commit", {bvalid, slv_reg[31:0]}, {1'b1, 32'h99});
      tick();
      check("race done", {bvalid, rvalid}, 2'b00);
      bready = 1'b0; rready = 1'b0;
      check("race regs", slv_reg, 128'h00000055_11BB33DD_DEADBEEF_00000099);

      // reset while a response is pending
      awaddr = 6'h08; awvalid = 1'b1; wdata = 32'h12; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      check("rst pending bvalid", bvalid, 1'b1);
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      check("rst bvalid", bvalid, 1'b0);
      check("rst regs", slv_reg, 128'h0);
      check("rst readys", {awready, wready, arready}, 3'b000);
      tick();
      check("rst readys back", {awready, wready, arready}, 3'b111);
      axi_write(6'h04, 32'h77, 4'hF, OKAY, 0, "post rst wr");
      axi_read(6'h04, 32'h77, OKAY, 0, "post rst rd");
      check("post rst regs", slv_reg, 128'h00000000_00000000_00000077_00000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/logmap_axil_slave.md
Name: logmap_axil_slave

Overview:
AXI4-Lite responder (slave) end of the logmap control interface. It accepts single-beat writes and reads from an AXI4-Lite initiator into four 32-bit control/status registers, then exposes those registers and per-register write pulses to the logistic-map datapath. It sits between the AXI interconnect and the logmap core.

Parameters:
C_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_ADDR_WIDTH, 6, AXI byte address width; decodes 16 words, of which 4 are implemented.
C_NUM_REGS, 4, number of implemented registers at word addresses 0..3.

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARESETN  in  1  reset, synchronous, active-low.
S_AXI_AWADDR  in  C_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte-lane enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  C_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read valid.
S_AXI_RREADY  in  1  read ready.
slv_reg_o  out  C_NUM_REGS*32  flattened registers; reg k occupies bits [32k+31:32k].
reg_wr_pulse_o  out  C_NUM_REGS  one-cycle pulse per register on write commit.

Behaviour:
- Reset (ARESETN=0 at a rising edge): all registers 0; all READY, VALID, RESP, RDATA and pulse outputs 0. All READY outputs are registered and rise on the first edge with ARESETN=1. Reset mid-transaction abandons it; no response is issued.
- Write FSM states are WR_IDLE, WR_COMMIT and WR_RESP.
  - WR_IDLE: AW and W are captured independently, in either order or in the same cycle, into holding flags and registers.
  - AWREADY=1 only while the AW flag is clear; WREADY=1 only while the W flag is clear.
  - When both flags are set, go to WR_COMMIT with both READYs low.
- WR_COMMIT (one cycle), word index = AWADDR[C_ADDR_WIDTH-1:2]:
  - If index < C_NUM_REGS, update byte lanes where WSTRB=1 and pulse reg_wr_pulse_o[index]. The pulse fires even when WSTRB=0.
  - Set BVALID on the same edge as the update, with BRESP=OKAY (2'b00). Clear both flags. Go to WR_RESP.
- WR_RESP: hold BVALID and BRESP stable until BREADY. On handshake, BVALID=0 and go to WR_IDLE; READYs reassert the next cycle.
  - Minimum write: AW+W handshake cycle N, commit/BVALID at N+1, next AWREADY at N+2 if BREADY was high at N+1.
- Address bits [1:0] are ignored, so unaligned addresses are word-truncated.
- Read FSM states are RD_IDLE and RD_DATA.
  - RD_IDLE: ARREADY=1. On ARVALID, latch RDATA on the same edge and go to RD_DATA with RVALID=1.
  - RDATA = register[index] when index < C_NUM_REGS, else 0. RRESP=OKAY.
  - RD_DATA: ARREADY=0; RDATA and RRESP are held until RREADY. Then RVALID=0, back to RD_IDLE, ARREADY=1 the next cycle.
  - Throughput is one read per 2 cycles minimum.
- Read and write channels are fully independent. If an AR handshake coincides with a WR_COMMIT to the same register, the read returns the pre-write value.
- VALID outputs never drop without a handshake. Inputs are not required to hold once their handshake completes.

Optional Feature:
LOGMAP_AXIL_SLVERR_EN
- Defined: accesses with index >= C_NUM_REGS return RESP=SLVERR (2'b10). Writes are dropped with no pulse; reads return RDATA=0.
- Undefined: such writes are silently dropped (no pulse) with BRESP=OKAY; such reads return 0 with RRESP=OKAY.

Decomposition:
- Package logmap_axil_pkg holds:
  - constants AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10;
  - typedefs wr_state_t {WR_IDLE, WR_COMMIT, WR_RESP} and rd_state_t {RD_IDLE, RD_DATA};
  - the reg-index typedef.
- One sub-module, logmap_axil_regfile: a strobed register array with write port (index, data, strobe, enable), combinational read by index, and pulse generation.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read the same addresses -> reads return 0x1..0x4 with RESP=OKAY; slv_reg_o=0x00000004_00000003_00000002_00000001; exactly one pulse per write.
- W presented 3 cycles before AW (0xDEADBEEF to 0x4) -> WREADY handshakes first, no commit until AW; BVALID 1 cycle after the AW handshake; reg1=0xDEADBEEF.
- reg2=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 to 0x8 -> reg2=0x11BB33DD; reg_wr_pulse_o[2] pulses once.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID, BRESP and RDATA stable; AWREADY/WREADY/ARREADY stay 0 until the handshake.
- Write to 0x20 and read 0x3C -> registers unchanged, no pulse, RDATA=0; RESP=OKAY without the macro, 2'b10 with LOGMAP_AXIL_SLVERR_EN.
- Assert ARESETN=0 for 1 cycle while BVALID=1 -> BVALID=0, all registers 0; the next write completes normally.
